mem_bus_unit: RTL

MEM_BUS_UNIT -- requirements
Module: mem_bus_unit

---
 rtl/mem_bus_pkg.sv | 17 +
 rtl/mem_timeout_ctr.sv | 37 +++
 rtl/mem_bus_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus unit.
// MEM_TIMEOUT_EN (optional) enables the transaction timeout in mem_bus_unit.
package mem_bus_pkg;

   localparam int WORD_W      = 16;
   localparam int TIMEOUT_CYC = 16;
   localparam int TMR_W       = $clog2(TIMEOUT_CYC);

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2
   } state_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Down-counter that flags expiry after TIMEOUT_CYC consecutive counting cycles.
// Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_timeout_ctr
   import mem_bus_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic count_i,
   input  logic clear_i,
   output logic expire_o
);

   localparam logic [TMR_W-1:0] CNT_INIT = TMR_W'(TIMEOUT_CYC - 1);

   logic [TMR_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = CNT_INIT;
      end else if (count_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - TMR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= CNT_INIT;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Terminal count reached on the last permitted waiting cycle.
   assign expire_o = count_i && (cnt_q == '0);

endmodule

// File: rtl/mem_bus_unit.sv
// Memory bus unit: MAR/MDR registers, datapath bus drive and a req/ack memory port.
// Define MEM_TIMEOUT_EN to abort stalled transactions and raise the sticky err flag.
//
// state | meaning
// IDLE  | no transaction; strobes load MAR/MDR and may start a transfer
// RD    | read outstanding, mem_req high, MDR captures mem_rdata on ack
// WR    | write outstanding, mem_req and mem_we high
module mem_bus_unit
   import mem_bus_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wmar,
   input  logic              rmar,
   input  logic              wmdr,
   input  logic              rmdr,
   input  logic              in_mdr1,
   input  logic              in_mdr2,
   input  logic              out_mdr1,
   input  logic              out_mdr2,
   input  logic              rm,
   input  logic              wmem,
   input  logic [WORD_W-1:0] bus_in,
   output logic [WORD_W-1:0] bus_out,
   output logic              bus_oe,
   output logic              busy,
   output logic [WORD_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic              mem_req,
   output logic              mem_we,
   input  logic              mem_ack,
   output logic              err
);

   state_e state_q, state_d;
   word_t  mar_q, mar_d;
   word_t  mdr_q, mdr_d;
   word_t  addr_q, addr_d;
   word_t  wdata_q, wdata_d;

   logic idle;
   logic start_wr;
   logic start_rd;
   logic timeout;

   assign idle     = (state_q == IDLE);
   // A simultaneous write request wins; the read is dropped.
   assign start_wr = idle && wmem && rmdr && out_mdr2;
   assign start_rd = idle && rm && in_mdr2 && wmdr && !start_wr;

`ifdef MEM_TIMEOUT_EN
   logic tmo_expire;
   logic err_q, err_d;

   mem_timeout_ctr u_timeout_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .count_i  (!idle),
      .clear_i  (idle),
      .expire_o (tmo_expire)
   );

   // An ack in the final waiting cycle still completes the transfer.
   assign timeout = tmo_expire && !mem_ack;
   assign err_d   = err_q || timeout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start_wr) begin
               state_d = WR;
            end else if (start_rd) begin
               state_d = RD;
            end
         end
         RD, WR: begin
            if (mem_ack || timeout) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // mem_req/mem_we come straight from the state register so they never glitch.
   always_comb begin
      mem_req   = (state_q != IDLE);
      mem_we    = (state_q == WR);
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      busy      = rst_n && (start_wr || start_rd || !idle);
   end

   always_comb begin
      mar_d   = mar_q;
      mdr_d   = mdr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (idle) begin
         if (wmar) begin
            mar_d = bus_in;
         end
         if (wmdr && in_mdr1) begin
            mdr_d = bus_in;
         end
         if (start_wr) begin
            addr_d  = mar_q;
            wdata_d = mdr_q;
         end else if (start_rd) begin
            addr_d = rmar ? mar_q : bus_in;
         end
      end else if ((state_q == RD) && mem_ack) begin
         mdr_d = mem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mar_q   <= '0;
         mdr_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         mar_q   <= mar_d;
         mdr_q   <= mdr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // MDR drive has priority; MAR is only driven when no memory access is requested.
   always_comb begin
      bus_out = '0;
      bus_oe  = 1'b0;
      if (rst_n) begin
         if (rmdr && out_mdr1) begin
            bus_out = mdr_q;
            bus_oe  = 1'b1;
         end else if (rmar && !rm && !wmem) begin
            bus_out = mar_q;
            bus_oe  = 1'b1;
         end
      end
   end

endmodule
